// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: true dual-port synchronous RAM with byte write enables,
// selectable read-during-write behaviour, optional output register, per-port
// read-valid flags, deterministic same-address conflict resolution and a
// post-reset clear sequencer that zeroes the array before traffic is accepted.
module dual_port_ram_be #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      ready,
    input  logic                      en_a,
    input  logic [DATA_WIDTH/8-1:0]   we_a,
    input  logic [ADDR_WIDTH-1:0]     addr_a,
    input  logic [DATA_WIDTH-1:0]     din_a,
    output logic [DATA_WIDTH-1:0]     dout_a,
    output logic                      valid_a,
    input  logic                      en_b,
    input  logic [DATA_WIDTH/8-1:0]   we_b,
    input  logic [ADDR_WIDTH-1:0]     addr_b,
    input  logic [DATA_WIDTH-1:0]     din_b,
    output logic [DATA_WIDTH-1:0]     dout_b,
    output logic                      valid_b,
    output logic                      collision
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic                    clr_we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    acc_a, acc_b;
    logic                    wr_a, wr_b_req, wr_b;
    logic                    same_addr, conflict;
    logic [DATA_WIDTH-1:0]   old_a, old_b, new_a, new_b;
    logic [DATA_WIDTH-1:0]   rdata_a, rdata_b;

    logic                    vld_a_p1, vld_b_p1, col_p1;
    logic [DATA_WIDTH-1:0]   data_a_p1, data_b_p1;

    // Overlay the enabled byte lanes of a new word onto an old word.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         lanes
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NB; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    // Clear-sequencer state register; reset lands in CLEAR only when clearing is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
        else     state <= state_nxt;
    end

    // Next state: leave CLEAR once the last word has been zeroed.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_addr == LAST_ADDR) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Sequencer outputs: zero-word write strobe while clearing.
    always_comb begin
        clr_we = 1'b0;
        if (state == CLEAR) clr_we = 1'b1;
    end

    // Clear address counter and ready flag; ready trails RUN by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr <= '0;
            ready    <= 1'b0;
        end else begin
            ready <= (state == RUN);
            if (clr_we) clr_addr <= clr_addr + 1'b1;
        end
    end

    // Request decode and conflict resolution: on a both-write clash A wins outright.
    always_comb begin
        acc_a     = en_a & ready;
        acc_b     = en_b & ready;
        same_addr = (addr_a == addr_b);
        wr_a      = acc_a & (|we_a);
        wr_b_req  = acc_b & (|we_b);
        wr_b      = wr_b_req & ~(wr_a & same_addr);
        conflict  = acc_a & acc_b & same_addr & ((|we_a) | (|we_b));
    end

    // Read words: old contents, merged write words, and per-port returned data.
    // A writing port whose write was discarded reports the word actually stored.
    always_comb begin
        old_a = mem[addr_a];
        old_b = mem[addr_b];
        new_a = merge_lanes(old_a, din_a, we_a);
        new_b = merge_lanes(old_b, din_b, we_b);
        rdata_a = old_a;
        rdata_b = old_b;
        if (RDW_MODE == 1) begin
            if (|we_a) rdata_a = new_a;
            if (|we_b) rdata_b = (wr_a && same_addr) ? new_a : new_b;
        end
    end

    // Array writes: clear sequencer, then byte-lane writes from both ports.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b && we_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
                if (wr_a && we_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
            end
        end
    end

    // Stage p1: capture read data at the accept edge; data holds between accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_a_p1  <= 1'b0;
            vld_b_p1  <= 1'b0;
            col_p1    <= 1'b0;
            data_a_p1 <= '0;
            data_b_p1 <= '0;
        end else begin
            vld_a_p1 <= acc_a;
            vld_b_p1 <= acc_b;
            col_p1   <= conflict;
            if (acc_a) data_a_p1 <= rdata_a;
            if (acc_b) data_b_p1 <= rdata_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  vld_a_p2, vld_b_p2, col_p2;
            logic [DATA_WIDTH-1:0] data_a_p2, data_b_p2;

            // Stage p2: optional output register, data advances only with its valid.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_a_p2  <= 1'b0;
                    vld_b_p2  <= 1'b0;
                    col_p2    <= 1'b0;
                    data_a_p2 <= '0;
                    data_b_p2 <= '0;
                end else begin
                    vld_a_p2 <= vld_a_p1;
                    vld_b_p2 <= vld_b_p1;
                    col_p2   <= col_p1;
                    if (vld_a_p1) data_a_p2 <= data_a_p1;
                    if (vld_b_p1) data_b_p2 <= data_b_p1;
                end
            end

            assign dout_a    = data_a_p2;
            assign dout_b    = data_b_p2;
            assign valid_a   = vld_a_p2;
            assign valid_b   = vld_b_p2;
            assign collision = col_p2;
        end else begin : g_no_out_reg
            assign dout_a    = data_a_p1;
            assign dout_b    = data_b_p1;
            assign valid_a   = vld_a_p1;
            assign valid_b   = vld_b_p1;
            assign collision = col_p1;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_ram_be.sv
// tb_dual_port_ram_be: scoreboard bench for dual_port_ram_be. Two instances share
// the stimulus: u0 is read-first with latency 1, u1 is write-first with latency 2.
module tb_dual_port_ram_be;

    typedef struct packed {
        int          tag;
        logic        col;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic [1:0]  we_a = '0, we_b = '0;
    logic [3:0]  addr_a = '0, addr_b = '0;
    logic [15:0] din_a = '0, din_b = '0;

    logic        ready0, valid_a0, valid_b0, collision0;
    logic [15:0] dout_a0, dout_b0;
    logic        ready1, valid_a1, valid_b1, collision1;
    logic [15:0] dout_a1, dout_b1;

    exp_t qa0[$], qb0[$], qa1[$], qb1[$];

    int n_vec = 0;
    int n_err = 0;
    int tag   = 0;

    always #5 clk = ~clk;

    dual_port_ram_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
        .clk(clk), .rst(rst), .ready(ready0),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0), .valid_a(valid_a0),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b0), .valid_b(valid_b0),
        .collision(collision0)
    );

    dual_port_ram_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .rst(rst), .ready(ready1),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1), .valid_a(valid_a1),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b1), .valid_b(valid_b1),
        .collision(collision1)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Pop the oldest expectation for one port of one instance and compare it.
    task automatic chk(input int idx, input string pname, input logic vld,
                       input logic [15:0] dout, input logic col);
        exp_t e;
        bit   have;
        if (!vld) return;
        have = 1'b0;
        case (idx)
            0: if (qa0.size() > 0) begin e = qa0.pop_front(); have = 1'b1; end
            1: if (qb0.size() > 0) begin e = qb0.pop_front(); have = 1'b1; end
            2: if (qa1.size() > 0) begin e = qa1.pop_front(); have = 1'b1; end
            default: if (qb1.size() > 0) begin e = qb1.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_vec++;
            n_err++;
            $display("FAIL %s unexpected valid: got dout %0h, expected no valid", pname, dout);
        end else begin
            cmp($sformatf("%s data #%0d", pname, e.tag), {16'h0, dout}, {16'h0, e.data});
            cmp($sformatf("%s collision #%0d", pname, e.tag), {31'h0, col}, {31'h0, e.col});
        end
    endtask

    // Monitor: sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        chk(0, "u0.a", valid_a0, dout_a0, collision0);
        chk(1, "u0.b", valid_b0, dout_b0, collision0);
        chk(2, "u1.a", valid_a1, dout_a1, collision1);
        chk(3, "u1.b", valid_b1, dout_b1, collision1);
    end

    // One request cycle on both ports with hand-computed expected read words.
    task automatic cyc(input logic ea, input logic [1:0] wa, input logic [3:0] aa, input logic [15:0] da,
                       input logic eb, input logic [1:0] wb, input logic [3:0] ab, input logic [15:0] db,
                       input logic [15:0] xa0, input logic [15:0] xa1,
                       input logic [15:0] xb0, input logic [15:0] xb1, input logic xc);
        tag++;
        en_a = ea; we_a = wa; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; addr_b = ab; din_b = db;
        if (ea) begin
            qa0.push_back('{tag: tag, col: xc, data: xa0});
            qa1.push_back('{tag: tag, col: xc, data: xa1});
        end
        if (eb) begin
            qb0.push_back('{tag: tag, col: xc, data: xb0});
            qb1.push_back('{tag: tag, col: xc, data: xb1});
        end
        @(posedge clk);
        #1;
        en_a = 1'b0;
        en_b = 1'b0;
    endtask

    task automatic drive_dropped();
        en_a = 1'b1; we_a = 2'b11; addr_a = 4'd0; din_a = 16'hFFFF;
        en_b = 1'b1; we_b = 2'b11; addr_b = 4'd1; din_b = 16'hEEEE;
    endtask

    task automatic check_reset_outputs(input string tagname);
        cmp({tagname, " u0 ready"},     {31'h0, ready0},     32'h0);
        cmp({tagname, " u1 ready"},     {31'h0, ready1},     32'h0);
        cmp({tagname, " u0 dout_a"},    {16'h0, dout_a0},    32'h0);
        cmp({tagname, " u0 dout_b"},    {16'h0, dout_b0},    32'h0);
        cmp({tagname, " u1 dout_a"},    {16'h0, dout_a1},    32'h0);
        cmp({tagname, " u1 dout_b"},    {16'h0, dout_b1},    32'h0);
        cmp({tagname, " u0 valids"},    {30'h0, valid_a0, valid_b0}, 32'h0);
        cmp({tagname, " u1 valids"},    {30'h0, valid_a1, valid_b1}, 32'h0);
        cmp({tagname, " collisions"},   {30'h0, collision0, collision1}, 32'h0);
    endtask

    initial begin
        int ready_at;
        drive_dropped();

        // Reset, with requests held on that must be ignored.
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Interrupt the clear after eight cycles.
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("mid-clear reset");
        @(posedge clk);
        #2 rst = 1'b0;

        // Count edges until ready; no request may be accepted meanwhile.
        ready_at = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            cmp($sformatf("no valid while not ready, edge %0d", n),
                {28'h0, valid_a0, valid_b0, valid_a1, valid_b1}, 32'h0);
            if (ready0 && ready1) begin
                ready_at = n;
                break;
            end
        end
        en_a = 1'b0;
        en_b = 1'b0;
        cmp("edges until ready", ready_at, 17);

        // Read back the cleared array on both ports; addr 0 and 1 prove dropped writes.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 2'b00, 4'(i), 16'h0, 1'b1, 2'b00, 4'(15 - i), 16'h0,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        end

        // Byte enables on port A.
        cyc(1, 2'b11, 4'd3, 16'hABCD, 0, 2'b00, 4'd0, 16'h0, 16'h0000, 16'hABCD, 16'h0, 16'h0, 0);
        cyc(1, 2'b01, 4'd3, 16'h1234, 0, 2'b00, 4'd0, 16'h0, 16'hABCD, 16'hAB34, 16'h0, 16'h0, 0);
        cyc(1, 2'b00, 4'd3, 16'h0000, 0, 2'b00, 4'd0, 16'h0, 16'hAB34, 16'hAB34, 16'h0, 16'h0, 0);

        // Read-during-write on port A.
        cyc(1, 2'b11, 4'd5, 16'h1111, 0, 2'b00, 4'd0, 16'h0, 16'h0000, 16'h1111, 16'h0, 16'h0, 0);
        cyc(1, 2'b11, 4'd5, 16'h2222, 0, 2'b00, 4'd0, 16'h0, 16'h1111, 16'h2222, 16'h0, 16'h0, 0);
        cyc(1, 2'b00, 4'd5, 16'h0000, 0, 2'b00, 4'd0, 16'h0, 16'h2222, 16'h2222, 16'h0, 16'h0, 0);

        // Both ports write addr 7: A's low lane lands, B's write is discarded.
        cyc(1, 2'b01, 4'd7, 16'hAAAA, 1, 2'b11, 4'd7, 16'hBBBB, 16'h0000, 16'h00AA, 16'h0000, 16'h00AA, 1);
        // Both ports read addr 7: not a conflict.
        cyc(1, 2'b00, 4'd7, 16'h0000, 1, 2'b00, 4'd7, 16'h0000, 16'h00AA, 16'h00AA, 16'h00AA, 16'h00AA, 0);

        // A reads addr 2 while B writes it.
        cyc(1, 2'b11, 4'd2, 16'h5555, 0, 2'b00, 4'd0, 16'h0, 16'h0000, 16'h5555, 16'h0, 16'h0, 0);
        cyc(1, 2'b00, 4'd2, 16'h0000, 1, 2'b11, 4'd2, 16'h6666, 16'h5555, 16'h5555, 16'h5555, 16'h6666, 1);
        cyc(0, 2'b00, 4'd0, 16'h0000, 1, 2'b00, 4'd2, 16'h0000, 16'h0, 16'h0, 16'h6666, 16'h6666, 0);

        // Port B upper-lane write, read back on port A.
        cyc(0, 2'b00, 4'd0, 16'h0000, 1, 2'b10, 4'd9, 16'h1234, 16'h0, 16'h0, 16'h0000, 16'h1200, 0);
        cyc(1, 2'b00, 4'd9, 16'h0000, 0, 2'b00, 4'd0, 16'h0000, 16'h1200, 16'h1200, 16'h0, 16'h0, 0);

        // Drain, then confirm every expectation was consumed and outputs hold.
        repeat (6) @(posedge clk);
        #1;
        cmp("u0.a queue drained", qa0.size(), 0);
        cmp("u0.b queue drained", qb0.size(), 0);
        cmp("u1.a queue drained", qa1.size(), 0);
        cmp("u1.b queue drained", qb1.size(), 0);
        cmp("u0 dout_a hold", {16'h0, dout_a0}, 32'h1200);
        cmp("u0 dout_b hold", {16'h0, dout_b0}, 32'h0000);
        cmp("u1 dout_a hold", {16'h0, dout_a1}, 32'h1200);
        cmp("u1 dout_b hold", {16'h0, dout_b1}, 32'h1200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_be.md
# dual_port_ram_be

Parametrised true dual-port synchronous RAM, the next generation of the team's dual-port RAM. It adds per-byte write enables, a selectable read-during-write mode, an optional output pipeline register, and per-port read-valid flags. Simultaneous same-address accesses are resolved deterministically and flagged. A post-reset clear sequencer zeroes the whole array before the block accepts traffic. It sits between two independent masters, such as a DMA engine and a CPU port, that share one buffer in a single clock domain.

## Interface
- DATA_WIDTH, 16: word width. Must be a multiple of 8. NB = DATA_WIDTH/8 byte lanes.
- ADDR_WIDTH, 4: address width. DEPTH = 2**ADDR_WIDTH words.
- RDW_MODE, 0: own-port read-during-write. 0 = read-first (old word), 1 = write-first (merged new word).
- OUT_REG, 0: 0 = read latency 1; 1 = extra output register, read latency 2.
- CLEAR_ON_RESET, 1: 1 = zero all DEPTH words after reset; 0 = no clear.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ready  out  1  high when port requests are accepted.
- en_a, en_b  in  1  port request strobes.
- we_a, we_b  in  NB  byte write enables. Bit i covers data bits [8i+7:8i]. All zero = read.
- addr_a, addr_b  in  ADDR_WIDTH  word addresses.
- din_a, din_b  in  DATA_WIDTH  write data.
- dout_a, dout_b  out  DATA_WIDTH  read data. Holds its value between valid cycles.
- valid_a, valid_b  out  1  one-cycle pulse marking new dout.
- collision  out  1  one-cycle pulse: same-address conflict was resolved.

## Operation
- Accept condition for port x: en_x && ready. Requests while ready=0 are dropped, with no write and no valid pulse.
- Every accepted request returns a read word on dout_x, including writes.
- Write: for each lane i with we_x[i]=1, mem[addr_x] lane i <= din_x lane i. Other lanes are unchanged.
- Own-port read data on a write:
  - RDW_MODE=0: the word before the write.
  - RDW_MODE=1: the merged post-write word.
- Conflict: both ports accepted, addr_a==addr_b, and at least one we nonzero.
  - Both writing: port A's write is applied in full. Port B's write is discarded entirely, including lanes A did not enable.
  - One writing, one reading: the reading port returns the pre-write word. The writing port follows RDW_MODE.
  - Both dout values follow these rules. collision pulses.
- Both ports reading the same address is not a conflict. Both get the same word and collision stays 0.
- Clear sequencer (FSM):
  - States CLEAR and RUN.
  - CLEAR: counter clr_addr runs 0..DEPTH-1, one zero word written per clk, ready=0.
  - At clr_addr==DEPTH-1, the next state is RUN. ready=1 from the following cycle.
  - RUN: normal operation. ready=1.
- CLEAR_ON_RESET=0: the FSM goes straight to RUN. Memory contents are undefined until written.

## Timing
- Reset values while rst=1: dout_a=dout_b=0, valid_a=valid_b=0, collision=0, ready=0, clr_addr=0.
  - CLEAR_ON_RESET=1: state=CLEAR.
  - CLEAR_ON_RESET=0: state=RUN; ready rises on the first posedge after rst falls.
- After rst falls with CLEAR_ON_RESET=1, the clear takes exactly DEPTH posedges. ready rises at posedge DEPTH+1.
- rst asserted mid-clear or mid-run: all outputs drop immediately to their reset values. The clear restarts from address 0. In-flight reads are discarded and produce no valid pulse.
- Read latency, from the accept edge to dout/valid:
  - OUT_REG=0: 1 cycle.
  - OUT_REG=1: 2 cycles.
- collision is aligned with the valid pulses of the conflicting requests, not with the accept edge.
- Full throughput: one request per port per cycle, with back-to-back accepts allowed.
- The write takes effect at the accept edge. A read of the same address accepted on the next edge sees the new data.
- Address wrap: the address is exactly ADDR_WIDTH bits, so there is no out-of-range access.

## Test plan
- Clear: CLEAR_ON_RESET=1, ADDR_WIDTH=4. Release rst, then read every address on port A. Required: ready=0 for 16 cycles then 1; all 16 reads return 0x0000 with valid_a one cycle after accept.
- Byte enables: write 0xABCD to addr 3 with we_a=2'b11, then write 0x1234 to addr 3 with we_a=2'b01. Reading addr 3 must return 0xAB34.
- Read-during-write: addr 5 holds 0x1111; port A writes 0x2222 there with we_a=2'b11. Required: RDW_MODE=0 gives dout_a=0x1111; RDW_MODE=1 gives dout_a=0x2222; memory holds 0x2222 in both cases.
- Write collision: same cycle, A writes 0xAAAA (we_a=2'b01) and B writes 0xBBBB (we_b=2'b11) to addr 7, which held 0x0000. Required: collision pulses once; addr 7 reads 0x00AA.
- Read/write collision with OUT_REG=1: addr 2 holds 0x5555; A reads addr 2 while B writes 0x6666 to addr 2. Required: two cycles later dout_a=0x5555, valid_a=1, valid_b=1, collision=1.
- Reset mid-clear: assert rst at clear cycle 8, release it, then count cycles. Required: ready rises after 16 more clear cycles; requests issued while ready=0 give no valid pulse and no write.
